// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch port and the
//   load/store data port. One transaction is in flight at a time:
//     IDLE/RESP (accept) -> ISSUE (mem_en) -> WAIT x MEM_LAT -> RESP (rvalid)
//   Data wins contention, except after MAX_DATA_STREAK back-to-back data
//   grants taken while fetch was waiting; then fetch gets one grant.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ready)
//   if_ready            fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata  one-cycle fetch response / last fetched word
//   d_req/d_we/d_func3/d_addr/d_wdata  data request (held until d_ready)
//   d_ready             data accepted this cycle (combinational)
//   d_rvalid/d_rdata    one-cycle completion / last loaded word
//   mem_en/mem_we/mem_func3/mem_addr/mem_wdata  memory request side
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_en
module mem_arbiter #(
  parameter int MEM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int STW = $clog2(MAX_DATA_STREAK + 1);
  localparam int CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [STW-1:0] STREAK_MAX = STW'(MAX_DATA_STREAK);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(MEM_LAT - 1);

  // Fetches are always full-word reads.
  localparam logic [2:0] FUNC3_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q,    state_d;
  logic [STW-1:0]  streak_q,   streak_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic            owner_d_q,  owner_d_d;   // 1 = data port owns the slot
  logic            we_q,       we_d;
  logic [2:0]      func3_q,    func3_d;
  logic [31:0]     addr_q,     addr_d;
  logic [31:0]     wdata_q,    wdata_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     d_rdata_q,  d_rdata_d;

  logic accept_win;
  logic grant_d;
  logic grant_i;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    cnt_d      = cnt_q;
    owner_d_d  = owner_d_q;
    we_d       = we_q;
    func3_d    = func3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_d    = 1'b0;
    grant_i    = 1'b0;

    // RESP doubles as an accept cycle so continuous traffic needs no IDLE gap.
    accept_win = ((state_q == IDLE) || (state_q == RESP)) && !rst;

    if (accept_win) begin
      if (d_req && (!if_req || (streak_q != STREAK_MAX))) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end

    unique case (state_q)
      IDLE, RESP: begin
        if (grant_d) begin
          owner_d_d = 1'b1;
          we_d      = d_we;
          func3_d   = d_func3;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          state_d   = ISSUE;
          // Streak only counts data grants that made fetch wait.
          if (if_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STW'(1);
          end
        end else if (grant_i) begin
          owner_d_d = 1'b0;
          we_d      = 1'b0;
          func3_d   = FUNC3_WORD;
          addr_d    = if_addr;
          wdata_d   = 32'h0;
          streak_d  = '0;
          state_d   = ISSUE;
        end else begin
          state_d   = IDLE;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          // mem_rdata is valid in the final WAIT cycle; stores leave rdata alone.
          if (!we_q) begin
            if (owner_d_q) d_rdata_d  = mem_rdata;
            else           if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      cnt_q      <= '0;
      owner_d_q  <= 1'b0;
      we_q       <= 1'b0;
      func3_q    <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      cnt_q      <= cnt_d;
      owner_d_q  <= owner_d_d;
      we_q       <= we_d;
      func3_q    <= func3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_ready  = grant_i;
  assign d_ready   = grant_d;

  // Memory side is decoded from registered state only; the latched request
  // stays on the bus through WAIT and RESP.
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_func3 = func3_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rvalid = (state_q == RESP) && !owner_d_q;
  assign d_rvalid  = (state_q == RESP) &&  owner_d_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates one unified single-port memory between the instruction-fetch port and the load/store data port. This lets the core share a single RAM instead of separate instr_ram/data_ram. The block is a registered request/response FSM: it accepts one transaction, issues it to memory, waits a fixed latency, then returns a one-cycle response pulse. Data requests have priority, with a starvation guard for fetch.

Parameters:
MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata (legal values >=1)
MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is pending (legal values >=1)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held stable until if_ready
if_addr  input  32  fetch byte address
if_ready  output  1  fetch request accepted this cycle
if_rvalid  output  1  one-cycle fetch response pulse
if_rdata  output  32  fetched word; holds last value
d_req  input  1  data request; held stable until d_ready
d_we  input  1  1 = store, 0 = load
d_func3  input  3  access size/sign code, passed to memory
d_addr  input  32  data byte address
d_wdata  input  32  store data
d_ready  output  1  data request accepted this cycle
d_rvalid  output  1  one-cycle completion pulse (load or store)
d_rdata  output  32  load data; holds last load value
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_func3  output  3  access code to memory
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. A wait counter counts MEM_LAT cycles.
- Accept window: state IDLE or RESP. if_ready/d_ready are combinational and high only in the accept window, for the granted requester.
- Grant rule when both requests are present: data wins, unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Streak counter:
  - increments, saturating, when data is granted while if_req=1;
  - clears when fetch is granted;
  - unchanged when data is granted with if_req=0.
- On accept at cycle T:
  - latch owner, addr, we, func3, wdata;
  - fetch forces we=0, func3=3'b010, wdata=0.
  - Next state is ISSUE.
- No request in the accept window: next state is IDLE.
- ISSUE (cycle T+1): mem_en=1, mem_we=latched we. mem_addr/mem_func3/mem_wdata come from the latch.
- WAIT (cycles T+2 .. T+1+MEM_LAT):
  - mem_en=0, mem_we=0; mem_addr/func3/wdata held.
  - At the end of the last WAIT cycle, mem_rdata is captured into the owner's rdata register. Loads and fetches only; on a store, d_rdata is unchanged.
- RESP (cycle T+2+MEM_LAT): owner's rvalid=1 for exactly one cycle. A new accept in this same cycle is allowed.
- Throughput: one transaction per MEM_LAT+2 cycles with continuous requests. Accept-to-rvalid latency is MEM_LAT+2.
- mem_en is never high in two consecutive cycles. if_rvalid and d_rvalid are never high together.
- Requests that are not accepted are not latched. Requester inputs may change freely after ready.
- Addresses are not checked (no alignment check) and are passed through unchanged.
- Reset, evaluated at the edge while rst=1:
  - state=IDLE, streak=0;
  - if_rdata=d_rdata=0;
  - all mem_* outputs 0, rvalid outputs 0.
  - While rst=1, if_ready/d_ready=0.
- Reset mid-transaction: the transaction is dropped and no rvalid is produced. Accepts are possible in the first cycle with rst=0.

Test Plan:
1. Reset: rst=1 for 2 cycles with if_req=d_req=1 -> no ready, mem_en=0, rdata=0. First cycle after release: d_ready=1, if_ready=0.
2. Fetch, MEM_LAT=1: if_req, addr 0x100, accepted at T. Memory word 0x00500093.
   -> T+1: mem_en=1, mem_we=0, mem_func3=010, mem_addr=0x100.
   -> T+3: if_rvalid=1, if_rdata=0x00500093.
3. Store at T: d_we=1, func3=000, addr 0x20, wdata 0xAB, with d_rdata previously 0x1234.
   -> T+1: mem_we=1, mem_wdata=0xAB.
   -> T+3: d_rvalid=1; d_rdata stays 0x1234.
4. Contention, MAX_DATA_STREAK=4, both requests held high -> grant order D,D,D,D,I,D,D,D,D,I, with accepts every 3 cycles (MEM_LAT=1).
5. Load, MEM_LAT=3, func3=100, addr 0x44 -> mem_addr held at 0x44 for cycles T+1..T+4; d_rvalid at T+5; next accept possible at T+5.
6. Reset during WAIT, MEM_LAT=3: rst pulsed at T+2 -> no rvalid ever appears for that request; mem_* outputs 0; a new request is accepted in the first cycle after rst falls.
